// File: rtl/seq_recog_pkg.sv
// seq_recog_pkg: shared state encoding and requester ids for the recognizer scheduler
package seq_recog_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_e;
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester that did not win last time wins
module rr_arbiter2
  import seq_recog_pkg::*;
(
  input  logic v0_i,
  input  logic v1_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);
  assign gnt_valid_o = v0_i | v1_i;
  assign gnt_id_o    = (v0_i & v1_i) ? ~last_i : (v1_i ? ID_REQ1 : ID_REQ0);
endmodule

// File: rtl/seq_recog_scheduler.sv
// seq_recog_scheduler: shares one serial recognizer between two requesters, shifting each
// granted word MSB-first after a clear pulse and reporting the number of z hits per word
module seq_recog_scheduler
  import seq_recog_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [N_BITS-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [N_BITS-1:0] req1_data,
  output logic              req1_ready,
  output logic              rec_x,
  output logic              rec_clr,
  input  logic              rec_z,
  output logic              res_valid,
  output logic              res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_hit,
  output logic              busy
);
  localparam int IDX_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic id_q, id_d, last_q, last_d, rid_q, rid_d;
  logic gnt_valid, gnt_id;
  rr_arbiter2 u_arb (
    .v0_i       (req0_valid),
    .v1_i       (req1_valid),
    .last_i     (last_q),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rcnt_d     = rcnt_q;
    id_d       = id_q;
    last_d     = last_q;
    rid_d      = rid_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rec_x      = 1'b0;
    rec_clr    = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt_valid & (gnt_id == ID_REQ0);
        req1_ready = gnt_valid & (gnt_id == ID_REQ1);
        if (gnt_valid) begin
          shreg_d = gnt_id ? req1_data : req0_data;
          id_d    = gnt_id;
          last_d  = gnt_id;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        rec_clr = 1'b1;
        idx_d   = IDX_W'(N_BITS - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        rec_x   = shreg_q[N_BITS-1];
        cnt_d   = cnt_q + CNT_W'(rec_z && (cnt_q != CNT_MAX));
        shreg_d = {shreg_q[N_BITS-2:0], 1'b0};
        idx_d   = idx_q - 1'b1;
        if (idx_q == '0) begin
          rid_d   = id_q;
          rcnt_d  = cnt_d;
          state_d = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= ID_REQ1;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rid_q   <= rid_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign res_id    = rid_q;
  assign res_count = rcnt_q;
  assign res_hit   = |rcnt_q;
endmodule
